// File: rtl/lc_token_loader_if.sv
// Word stream feeding the lifecycle token loader.
interface lc_token_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_type;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_type,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_type,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/lc_token_loader.sv
// Lifecycle token loader: assembles transition and authentication IDs from a
// word stream, issues the lifecycle request, and locks out after repeated failures.
module lc_token_loader #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TOKEN_W        = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_ATTEMPTS   = 3
) (
  input  logic               clk,
  input  logic               rst,
  lc_token_loader_if.slave   strm,
  input  logic               abort,
  output logic [TOKEN_W-1:0] lc_transition_id,
  output logic               lc_transition_request_in,
  output logic [TOKEN_W-1:0] lc_authentication_id,
  output logic               lc_authentication_valid,
  output logic               busy,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               locked
);

  localparam int unsigned N     = TOKEN_W / WORD_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = (TOKEN_W > 1) ? $clog2(TOKEN_W) : 1;
  localparam int unsigned TMO_W = 16;
  localparam int unsigned ATT_W = 3;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_ORDER = 2'd1;
  localparam logic [1:0] CODE_FRAME = 2'd2;
  localparam logic [1:0] CODE_TMO   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_TID,
    ST_LOAD_AUTH,
    ST_ISSUE,
    ST_DONE,
    ST_ERROR,
    ST_LOCKED
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   word_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ATT_W-1:0]   attempts;
  logic               ready_q;

  logic               accept;
  logic               loading;
  logic               is_final;
  logic               exp_type;
  logic               abort_hit;
  logic               tmo_hit;
  logic               fail_now;
  logic [1:0]         word_code;
  logic [1:0]         fail_code;
  logic [CNT_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   word_base;
  logic [ATT_W-1:0]   att_inc;
  state_t             fail_state;

  assign strm.in_ready = ready_q;

  // Decode this cycle's event: word check, abort, timeout and failure target.
  always_comb begin
    accept     = strm.in_valid && ready_q;
    loading    = (state == ST_LOAD_TID) || (state == ST_LOAD_AUTH);
    cur_idx    = loading ? word_cnt : '0;
    is_final   = (cur_idx == LAST_IDX);
    exp_type   = (state == ST_LOAD_AUTH);
    word_base  = IDX_W'(cur_idx) * IDX_W'(WORD_W);
    word_code  = CODE_NONE;
    if (strm.in_type != exp_type) begin
      word_code = CODE_ORDER;
    end else if (strm.in_last != is_final) begin
      word_code = CODE_FRAME;
    end
    abort_hit  = abort && loading;
    tmo_hit    = loading && !accept && (tmo_cnt == TMO_LAST);
    fail_now   = !abort_hit && ((accept && (word_code != CODE_NONE)) || tmo_hit);
    fail_code  = accept ? word_code : CODE_TMO;
    att_inc    = attempts + ATT_W'(1);
    fail_state = (att_inc == ATT_MAX) ? ST_LOCKED : ST_ERROR;
  end

  // Loader state machine with registered outputs and token assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= ST_IDLE;
      word_cnt                 <= '0;
      tmo_cnt                  <= '0;
      attempts                 <= '0;
      ready_q                  <= 1'b1;
      lc_transition_id         <= '0;
      lc_transition_request_in <= 1'b0;
      lc_authentication_id     <= '0;
      lc_authentication_valid  <= 1'b0;
      busy                     <= 1'b0;
      err                      <= 1'b0;
      err_code                 <= CODE_NONE;
      locked                   <= 1'b0;
    end else begin
      lc_transition_request_in <= 1'b0;
      if (abort_hit) begin
        // Software abort drops the partial load without counting an attempt.
        state                <= ST_IDLE;
        ready_q              <= 1'b1;
        busy                 <= 1'b0;
        word_cnt             <= '0;
        tmo_cnt              <= '0;
        lc_transition_id     <= '0;
        lc_authentication_id <= '0;
      end else if (fail_now) begin
        // Any failure discards partial tokens; the offending word is dropped.
        state                   <= fail_state;
        ready_q                 <= (fail_state != ST_LOCKED);
        locked                  <= (fail_state == ST_LOCKED);
        busy                    <= 1'b0;
        err                     <= 1'b1;
        err_code                <= fail_code;
        attempts                <= att_inc;
        word_cnt                <= '0;
        tmo_cnt                 <= '0;
        lc_transition_id        <= '0;
        lc_authentication_id    <= '0;
        lc_authentication_valid <= 1'b0;
      end else if (accept) begin
        tmo_cnt <= '0;
        case (state)
          ST_LOAD_TID: begin
            lc_transition_id[word_base +: WORD_W] <= strm.in_data;
            if (is_final) begin
              state    <= ST_LOAD_AUTH;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
          ST_LOAD_AUTH: begin
            lc_authentication_id[word_base +: WORD_W] <= strm.in_data;
            if (is_final) begin
              state                    <= ST_ISSUE;
              ready_q                  <= 1'b0;
              word_cnt                 <= '0;
              lc_transition_request_in <= 1'b1;
              lc_authentication_valid  <= 1'b1;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
          default: begin
            // First word of a new load from IDLE, DONE or ERROR.
            lc_transition_id        <= TOKEN_W'(strm.in_data);
            lc_authentication_id    <= '0;
            lc_authentication_valid <= 1'b0;
            err                     <= 1'b0;
            err_code                <= CODE_NONE;
            busy                    <= 1'b1;
            if (is_final) begin
              state    <= ST_LOAD_AUTH;
              word_cnt <= '0;
            end else begin
              state    <= ST_LOAD_TID;
              word_cnt <= CNT_W'(1);
            end
          end
        endcase
      end else begin
        if (loading) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        if (state == ST_ISSUE) begin
          state    <= ST_DONE;
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          attempts <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc_token_loader.sv
// Directed-plus-random bench for lc_token_loader against a queue-based token model.
module tb_lc_token_loader;

  localparam int unsigned WW   = 32;
  localparam int unsigned TW   = 256;
  localparam int unsigned N    = TW / WW;
  localparam int unsigned T    = 1024;
  localparam int unsigned MAXA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic [TW-1:0] tid;
  logic          req;
  logic [TW-1:0] auth;
  logic          aval;
  logic          busy;
  logic          err;
  logic [1:0]    ecode;
  logic          locked;

  lc_token_loader_if #(.WORD_W(WW)) bus ();

  lc_token_loader #(
    .WORD_W(WW), .TOKEN_W(TW), .TIMEOUT_CYCLES(T), .MAX_ATTEMPTS(MAXA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .strm(bus),
    .abort(abort),
    .lc_transition_id(tid),
    .lc_transition_request_in(req),
    .lc_authentication_id(auth),
    .lc_authentication_valid(aval),
    .busy(busy),
    .err(err),
    .err_code(ecode),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  always @(negedge clk) if (req === 1'b1) pulses++;

  // Reference model: mode 0 = not loading, 1 = collecting TID, 2 = collecting auth.
  int          m_mode;
  logic [31:0] tid_q[$];
  logic [31:0] auth_q[$];
  logic        m_err;
  logic [1:0]  m_code;
  int          m_att;
  logic        m_locked;
  logic        m_aval;
  logic        m_done;
  int          m_idle;
  int          exp_pulses = 0;

  function automatic logic [TW-1:0] pack(input logic [31:0] q[$]);
    logic [TW-1:0] r = '0;
    for (int i = 0; i < q.size(); i++) r = r | (TW'(q[i]) << (i * WW));
    return r;
  endfunction

  task automatic m_reset();
    m_mode = 0; tid_q.delete(); auth_q.delete();
    m_err = 0; m_code = 0; m_att = 0; m_locked = 0; m_aval = 0; m_done = 0; m_idle = 0;
  endtask

  task automatic m_fail(input logic [1:0] c);
    m_err = 1; m_code = c; m_att++;
    tid_q.delete(); auth_q.delete();
    m_aval = 0; m_mode = 0; m_idle = 0;
    if (m_att == MAXA) m_locked = 1;
  endtask

  task automatic m_gap(input int g);
    m_idle += g;
    if (m_mode != 0 && m_idle >= T) m_fail(2'd3);
  endtask

  task automatic m_abort();
    if (m_mode != 0) begin
      m_mode = 0; tid_q.delete(); auth_q.delete(); m_idle = 0;
    end
  endtask

  task automatic m_word(input logic t, input logic l, input logic [31:0] d);
    m_done = 0; m_idle = 0;
    if (m_mode == 0) begin
      if (t) m_fail(2'd1);
      else if (l) m_fail(2'd2);
      else begin
        tid_q.delete(); auth_q.delete(); tid_q.push_back(d);
        m_err = 0; m_code = 0; m_aval = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (t) m_fail(2'd1);
      else if (l != (tid_q.size() == N - 1)) m_fail(2'd2);
      else begin
        tid_q.push_back(d);
        if (tid_q.size() == N) m_mode = 2;
      end
    end else begin
      if (!t) m_fail(2'd1);
      else if (l != (auth_q.size() == N - 1)) m_fail(2'd2);
      else begin
        auth_q.push_back(d);
        if (auth_q.size() == N) begin
          m_mode = 0; m_aval = 1; m_att = 0; exp_pulses++; m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_busy"},   TW'(busy),         TW'(m_mode != 0));
    chk({tag, "_err"},    TW'(err),          TW'(m_err));
    chk({tag, "_code"},   TW'(ecode),        TW'(m_code));
    chk({tag, "_locked"}, TW'(locked),       TW'(m_locked));
    chk({tag, "_ready"},  TW'(bus.in_ready), TW'(!m_locked));
    chk({tag, "_aval"},   TW'(aval),         TW'(m_aval));
    chk({tag, "_tid"},    tid,               pack(tid_q));
    chk({tag, "_auth"},   auth,              pack(auth_q));
    chk({tag, "_pulses"}, TW'(pulses),       TW'(exp_pulses));
  endtask

  // Presents one word after gap idle cycles; returns one cycle after acceptance.
  task automatic send(input logic t, input logic l, input logic [31:0] d,
                      input int gap, input logic ab);
    bit acc = 0;
    bit exp_acc;
    int n = 0;
    m_gap(gap);
    exp_acc = !m_locked;
    repeat (gap) @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_type = t; bus.in_last = l; bus.in_data = d; abort = ab;
    while (!acc && n < 16) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0; abort = 1'b0; bus.in_data = $urandom;
    chk("accept", TW'(acc), TW'(exp_acc));
    m_done = 0;
    if (acc) begin
      if (ab) m_abort();
      else m_word(t, l, d);
    end
    if (m_done) begin
      chk("req_hi",      TW'(req),          TW'(1'b1));
      chk("busy_issue",  TW'(busy),         TW'(1'b1));
      chk("ready_issue", TW'(bus.in_ready), TW'(1'b0));
      @(posedge clk);
      #1;
      chk("req_lo",      TW'(req),          TW'(1'b0));
    end
  endtask

  task automatic idle(input int g);
    m_gap(g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  function automatic int pick_gap(input int maxgap);
    if (maxgap == 0) return 0;
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(500, maxgap));
    return int'($urandom_range(0, 5));
  endfunction

  task automatic send_tid(input int cnt, input int maxgap, input bit rnd);
    for (int i = 0; i < cnt; i++)
      send(1'b0, (i == N - 1), rnd ? $urandom : 32'(32'h11111111 * (i + 1)), pick_gap(maxgap), 1'b0);
  endtask

  task automatic send_auth(input int cnt, input int maxgap, input bit rnd);
    for (int i = 0; i < cnt; i++)
      send(1'b1, (i == N - 1), rnd ? $urandom : 32'(32'hA0 + i), pick_gap(maxgap), 1'b0);
  endtask

  task automatic full_load(input string tag, input int maxgap, input bit rnd);
    send_tid(N, maxgap, rnd);
    send_auth(N, maxgap, rnd);
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_type = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    m_reset();
    #1;
    check_all("reset");
    chk("reset_req", TW'(req), TW'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("post_reset");

    // Nominal load against fixed constants.
    full_load("nominal", 0, 0);
    chk("nominal_tid_const",  tid,
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    chk("nominal_auth_const", auth,
        256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);

    // Random data with random gaps below the timeout.
    full_load("gaps_rand", 1000, 1);

    // Timeout boundary: gap of T-1 is tolerated, T idle cycles fault.
    send_tid(2, 0, 1);
    send(1'b0, 1'b0, $urandom, T - 1, 1'b0);
    check_all("tmo_edge_ok");
    idle(T - 1);
    check_all("tmo_almost");
    idle(1);
    check_all("tmo_hit");

    // Early in_last on the 5th TID word, then recovery.
    send_tid(4, 0, 1);
    send(1'b0, 1'b1, $urandom, 0, 1'b0);
    check_all("frame_err");
    full_load("frame_recover", 0, 1);

    // Auth-type word inside the TID phase, then recovery.
    send_tid(2, 0, 1);
    send(1'b1, 1'b0, $urandom, 0, 1'b0);
    check_all("order_err");
    full_load("order_recover", 3, 0);

    // Two errors, an abort that must not count, then a third error locks.
    send(1'b1, 1'b0, $urandom, 0, 1'b0);
    check_all("lk_err1");
    send(1'b0, 1'b1, $urandom, 0, 1'b0);
    check_all("lk_err2");
    send_tid(N, 0, 1);
    send_auth(2, 0, 1);
    send(1'b1, 1'b0, $urandom, 0, 1'b1);
    check_all("abort");
    send(1'b1, 1'b0, $urandom, 0, 1'b0);
    check_all("locked");
    send(1'b0, 1'b0, $urandom, 0, 1'b0);
    check_all("locked_ignore");
    do_reset();
    check_all("unlock_reset");
    full_load("after_lock", 0, 0);

    // Asynchronous reset in the middle of the auth phase.
    send_tid(N, 0, 1);
    send_auth(3, 0, 1);
    #1 rst = 1'b1;
    #1;
    m_reset();
    check_all("async_rst");
    chk("async_rst_req", TW'(req), TW'(1'b0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("async_rst_after");
    full_load("final", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc_token_loader.md
Name: lc_token_loader

Overview:
- Upstream front-end for the MCSE lifecycle port: collects a 256-bit transition ID and a 256-bit authentication ID as 32-bit words over a valid/ready stream.
- Once both tokens are complete, raises the lifecycle request and authentication-valid pair that feed mcse_top (lc_transition_id, lc_transition_request_in, lc_authentication_id, lc_authentication_valid).
- Counts framing errors and timeouts, and locks out after repeated failures.

Parameters:
- WORD_W, 32, stream word width; TOKEN_W must be an integer multiple of it.
- TOKEN_W, 256, width of each token.
- TIMEOUT_CYCLES, 1024, maximum idle gap between words inside a load; legal range 2 to 2^16-1.
- MAX_ATTEMPTS, 3, error count that forces LOCKED; legal range 1 to 7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream ready.
- in_data  in  WORD_W  stream word.
- in_type  in  1  0 = transition-ID word, 1 = auth-ID word.
- in_last  in  1  marks the final word of a token.
- abort  in  1  software abort of the load in progress.
- lc_transition_id  out  TOKEN_W  assembled transition ID.
- lc_transition_request_in  out  1  one-cycle request pulse.
- lc_authentication_id  out  TOKEN_W  assembled auth ID.
- lc_authentication_valid  out  1  auth ID valid level.
- busy  out  1  high in LOAD_TID, LOAD_AUTH or ISSUE.
- err  out  1  sticky error flag; cleared by the next accepted first word.
- err_code  out  2  1 = type/order, 2 = in_last framing, 3 = timeout.
- locked  out  1  lockout indicator.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - All outputs 0 except in_ready = 1.
  - Both token registers, word count, timeout counter and attempt count = 0.
- Handshake: a word is accepted when in_valid && in_ready. in_ready = 1 in IDLE, LOAD_TID, LOAD_AUTH, DONE and ERROR; 0 in ISSUE and LOCKED.
- Packing: word index k (0..TOKEN_W/WORD_W-1) writes bits [k*WORD_W +: WORD_W]. The first word fills the LSBs.
- N = TOKEN_W/WORD_W (8 at defaults).
- States and transitions:
  - IDLE / DONE / ERROR:
    - An accepted word with type 0 clears both token registers, writes word 0 and goes to LOAD_TID with count = 1.
    - That first word clears err, err_code and lc_authentication_valid.
    - An accepted word with type 1 is an order error (code 1).
    - in_last on word 0 with N>1 is a framing error (code 2).
  - LOAD_TID:
    - Each accepted type-0 word writes index count, then count increments.
    - The word at count = N-1 must have in_last = 1; it then goes to LOAD_AUTH with count = 0.
    - in_last earlier than N-1, missing at N-1, or a type-1 word is an error.
  - LOAD_AUTH: same rules with type 1 into lc_authentication_id. The final word goes to ISSUE.
  - ISSUE (exactly 1 cycle):
    - lc_transition_request_in = 1 and lc_authentication_valid = 1.
    - Attempt count resets to 0.
    - Next state is DONE.
  - DONE:
    - Request pulse is 0; lc_authentication_valid stays 1.
    - Both tokens hold their values until a new load starts.
- Acceptance latency: the request pulse occurs in the cycle after the final auth word is accepted.
- Timeout:
  - The counter runs in LOAD_TID and LOAD_AUTH and clears on every accepted word.
  - Reaching TIMEOUT_CYCLES is an error (code 3).
- Error action, taken in the same cycle as the error:
  - err = 1; err_code set; attempt count increments.
  - Partial tokens are cleared; lc_authentication_valid = 0.
  - Next state is ERROR, or LOCKED if the incremented count equals MAX_ATTEMPTS.
  - The offending word is consumed, not retained.
- abort:
  - In LOAD_TID or LOAD_AUTH: clears the partial tokens and count and returns to IDLE. No error is raised and no attempt is counted.
  - In other states it is ignored.
  - abort takes priority over a simultaneous word accept or timeout.
- Simultaneity: when a word accept and the timeout terminal count coincide, the word wins and the counter clears.
- LOCKED:
  - locked = 1, in_ready = 0, and all token outputs are 0.
  - Only rst exits this state.
- Reset during a load: all state is lost and the block returns to IDLE immediately. No request pulse is produced.

Test Plan:
- Nominal load: 8 type-0 words 0x11111111..0x88888888 (last on the 8th), then 8 type-1 words 0xA0..0xA7.
  - Required: lc_transition_id = 0x88888888_..._11111111, a single request pulse 1 cycle after the last accept, auth_valid held at 1, busy returns to 0.
- Back-pressure and gaps: in_valid toggled with random gaps up to 1000 cycles.
  - Required: identical result to nominal; no timeout.
  - A gap of 1024 cycles gives err = 1, err_code = 3, state ERROR.
- Framing errors:
  - in_last on the 5th TID word gives err_code = 2.
  - A type-1 word in LOAD_TID gives err_code = 1.
  - A following valid load clears err and completes.
- Lockout: three consecutive errors give locked = 1 and in_ready = 0. Further words are ignored; only rst clears the state.
- Abort: abort asserted on the 3rd auth word, simultaneous with in_valid.
  - Required: state IDLE, tokens 0, err = 0, attempts unchanged.
  - A subsequent nominal load succeeds.
- Async reset mid-LOAD_AUTH: rst pulsed between clock edges.
  - Required: outputs return to reset values immediately; no request pulse, auth_valid = 0.
